// File: rtl/cpu_bank_reg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_bank_reg
// Description : CPU register bank with two combinational read ports, one
//               synchronous write port, optional write-to-read bypass,
//               optional hardwired zero register and a post-reset
//               sequential clear engine that raises ready when done.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_bank_reg #(
  parameter int NUM_REGS  = 16,
  parameter int REG_WIDTH = 32,
  parameter int ZERO_REG  = 1,
  parameter int BYPASS    = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [$clog2(NUM_REGS)-1:0] read_reg_a,
  input  logic [$clog2(NUM_REGS)-1:0] read_reg_b,
  input  logic [$clog2(NUM_REGS)-1:0] write_reg,
  input  logic [REG_WIDTH-1:0]        write_data,
  input  logic                        write_enable,
  output logic [REG_WIDTH-1:0]        read_data_a,
  output logic [REG_WIDTH-1:0]        read_data_b,
  output logic                        ready
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [IDX_W-1:0]     clear_idx;
  logic [IDX_W-1:0]     clear_idx_next;
  logic                 ready_next;
  logic                 user_write;
  logic [REG_WIDTH-1:0] mem [NUM_REGS];

  // Writes to r0 are dropped when it is hardwired to zero.
  assign user_write = write_enable && !((ZERO_REG == 1) && (write_reg == '0));

  // State register: reset restarts the clear sequence from index 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= CLEAR;
      clear_idx <= '0;
      ready     <= 1'b0;
    end else begin
      state     <= state_next;
      clear_idx <= clear_idx_next;
      ready     <= ready_next;
    end
  end

  // Next-state logic: walk clear_idx up to the last register, then go IDLE.
  always_comb begin
    state_next     = state;
    clear_idx_next = clear_idx;
    ready_next     = ready;
    case (state)
      CLEAR: begin
        clear_idx_next = clear_idx + 1'b1;
        if (clear_idx == LAST_IDX) begin
          state_next = IDLE;
          ready_next = 1'b1;
        end
      end
      IDLE: begin
        ready_next = 1'b1;
      end
      default: begin
        state_next = CLEAR;
        ready_next = 1'b0;
      end
    endcase
  end

  // Storage update: clear engine owns the array during CLEAR, user write in IDLE;
  // the reset cycle itself leaves contents untouched.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == CLEAR) begin
        mem[clear_idx] <= '0;
      end else if ((state == IDLE) && user_write) begin
        mem[write_reg] <= write_data;
      end
    end
  end

  // Read port A: zero register beats bypass, bypass beats stored value.
  always_comb begin
    read_data_a = '0;
    if (state == IDLE) begin
      if ((ZERO_REG == 1) && (read_reg_a == '0)) begin
        read_data_a = '0;
      end else if ((BYPASS == 1) && write_enable && (write_reg == read_reg_a)) begin
        read_data_a = write_data;
      end else begin
        read_data_a = mem[read_reg_a];
      end
    end
  end

  // Read port B: same priority as port A, fully independent.
  always_comb begin
    read_data_b = '0;
    if (state == IDLE) begin
      if ((ZERO_REG == 1) && (read_reg_b == '0)) begin
        read_data_b = '0;
      end else if ((BYPASS == 1) && write_enable && (write_reg == read_reg_b)) begin
        read_data_b = write_data;
      end else begin
        read_data_b = mem[read_reg_b];
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/cpu_bank_reg.md
Name: cpu_bank_reg

Overview:
- Register bank: the slave end of the CPU bank-register interface, driven by the decode/writeback stages as master.
- Provides two combinational read ports and one synchronous write port.
- Optional same-cycle write-to-read bypass and an optional hardwired zero register.
- After reset, a sequential clear engine zeroes every register, one per cycle, and signals ready when done.

Parameters:
- NUM_REGS, 16, number of architectural registers; power of two, at least 2.
- REG_WIDTH, 32, data width of each register.
- ZERO_REG, 1, when 1, register 0 always reads 0 and writes to it are discarded.
- BYPASS, 1, when 1, a read of the register being written this cycle returns write_data.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- read_reg_a  input  $clog2(NUM_REGS)  read port A register index.
- read_reg_b  input  $clog2(NUM_REGS)  read port B register index.
- write_reg  input  $clog2(NUM_REGS)  write register index.
- write_data  input  REG_WIDTH  write data.
- write_enable  input  1  commits write_data to write_reg at the next rising edge.
- read_data_a  output  REG_WIDTH  port A data.
- read_data_b  output  REG_WIDTH  port B data.
- ready  output  1  high once the clear sequence has completed; bank usable.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- FSM states:
  - CLEAR: entered on any cycle with reset=1, including mid-operation.
  - IDLE: normal operation.
- While reset=1:
  - state <= CLEAR, clear_idx <= 0, ready <= 0.
  - Register contents are not altered in the reset cycle itself.
- CLEAR:
  - Each cycle: mem[clear_idx] <= 0, clear_idx <= clear_idx+1.
  - On the cycle clear_idx == NUM_REGS-1, transition to IDLE and set ready <= 1 at that edge.
  - First IDLE cycle is therefore NUM_REGS cycles after reset deasserts.
  - write_enable is ignored; no write occurs and none is queued.
  - read_data_a/b are forced to 0.
- IDLE:
  - Write: if write_enable=1, and not (ZERO_REG=1 and write_reg=0), mem[write_reg] <= write_data at the rising edge.
  - Read: combinational, read_data_x = mem[read_reg_x].
  - Read overrides, highest priority first:
    - (a) ZERO_REG=1 and read_reg_x=0 -> 0.
    - (b) BYPASS=1 and write_enable=1 and write_reg=read_reg_x -> write_data, same cycle, zero latency.
    - (c) otherwise the stored value.
  - Rule (a) beats (b), so a write to r0 never bypasses.
  - BYPASS=0: a read of the register being written returns the old value; the new value is visible from the next cycle.
- Ports A and B are independent. Both may address the same register, and both receive identical data.
- Only one write port, so write conflicts are impossible.
- ready stays 1 in IDLE until the next reset.
- Indices: all index values are in range by construction (power-of-two NUM_REGS); no wrap handling is needed beyond clear_idx terminating at NUM_REGS-1.
- Outputs after reset:
  - ready=0, read_data_a=0, read_data_b=0 throughout CLEAR.
  - All registers read 0 on entry to IDLE.

Test Plan:
- Reset clear: preload r5=0xDEADBEEF, assert reset 1 cycle, hold write_enable=1 during clear.
  - ready rises exactly 16 cycles after reset deasserts.
  - read_data_a=0 throughout CLEAR.
  - r5 reads 0 afterwards.
  - No write lands during CLEAR.
- Write then read: IDLE, write r3=0x12345678.
  - Next cycle read_reg_a=3 and read_reg_b=3 both return 0x12345678.
- Bypass: BYPASS=1, write_enable=1, write_reg=7, write_data=0xA5A5A5A5, read_reg_a=7, same cycle.
  - read_data_a=0xA5A5A5A5 combinationally.
  - With BYPASS=0, the old value is returned; the new value appears the next cycle.
- Zero register: ZERO_REG=1, write r0=0xFFFFFFFF with read_reg_a=0 in the same cycle and the following cycle.
  - read_data_a=0 in both cycles.
  - With ZERO_REG=0, r0 stores and bypasses like any other register.
- Mid-operation reset: reset asserted while in IDLE after writing r1..r15=index values.
  - ready drops to 0 the next cycle.
  - The full 16-cycle clear reruns.
  - All registers read 0.
  - Reset reasserted on the 8th clear cycle restarts clear_idx at 0, and ready is delayed accordingly.
- Dual-port independence: r2=0x11, r9=0x22, read_reg_a=2, read_reg_b=9.
  - read_data_a=0x11, read_data_b=0x22.
  - Swapping the indices swaps the outputs in the same cycle.
